// File: rtl/lsu_pkg.sv
// Shared types and width-code helpers for the load/store alignment unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes; illegal codes report 8 and are rejected by is_legal.
  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 1;
      F3_H, F3_HU: return 2;
      F3_W, F3_WU: return 4;
      default:     return 8;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] f3, input int unsigned dw);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      F3_D, F3_WU:                    return (dw == 64);
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_unit_lane.sv
// Combinational lane steering: strobes and shifted store data across LANES bus
// words, plus load extraction and sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 2,
  localparam int unsigned BYTES = DATA_W / 8,
  localparam int unsigned OFF_W = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0]         i_off,
  input  logic [2:0]               i_funct3,
  input  logic [DATA_W-1:0]        i_wdat,
  input  logic [LANES*DATA_W-1:0]  i_rdat,
  output logic [LANES*BYTES-1:0]   o_strobe,
  output logic [LANES*DATA_W-1:0]  o_wdat,
  output logic [DATA_W-1:0]        o_ldat
);

  int unsigned             w_sz;
  logic [LANES*BYTES-1:0]  w_base;
  logic [DATA_W-1:0]       w_low;
  logic                    w_sext;
  logic                    w_sgn;

  assign w_sz   = size_of(i_funct3);
  assign w_sext = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);

  always_comb begin
    w_base = '0;
    for (int unsigned i = 0; i < LANES * BYTES; i++) begin
      w_base[i] = (i < w_sz);
    end
    o_strobe = w_base << i_off;
    o_wdat   = (LANES * DATA_W)'(i_wdat) << {i_off, 3'b000};
  end

  always_comb begin
    w_low = DATA_W'(i_rdat >> {i_off, 3'b000});
    w_sgn = 1'b0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i + 1 == w_sz) w_sgn = w_low[8*i+7];
    end
    o_ldat = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      o_ldat[8*i +: 8] = (i < w_sz) ? w_low[8*i +: 8] : {8{w_sext & w_sgn}};
    end
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: one outstanding bus beat at a time, optional
// two-beat split of misaligned accesses when MISALIGN_SPLIT_EN is defined.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_W-1:0]     ad,
  input  logic [DATA_W-1:0]     inDat,
  output logic                  memValid,
  input  logic                  memReady,
  output logic                  memWe,
  output logic [ADDR_W-1:0]     memAd,
  output logic [DATA_W-1:0]     memWdat,
  output logic [DATA_W/8-1:0]   memStrobe,
  input  logic                  memRvalid,
  input  logic [DATA_W-1:0]     memRdat,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [DATA_W-1:0]     respDat,
  output logic                  respErr
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
`ifdef MISALIGN_SPLIT_EN
  localparam int unsigned LANES = 2;
`else
  localparam int unsigned LANES = 1;
`endif

  lsu_state_t              r_state, w_next;
  logic [ADDR_W-1:0]       r_ad;
  logic [DATA_W-1:0]       r_dat;
  logic [2:0]              r_f3;
  logic                    r_we;
  logic                    r_err;
  logic [DATA_W-1:0]       r_resp_dat;

  logic                    w_accept;
  logic                    w_bad;
  logic                    w_two;
  logic [ADDR_W-1:0]       w_base;
  logic [LANES*BYTES-1:0]  w_strobe;
  logic [LANES*DATA_W-1:0] w_wdat;
  logic [LANES*DATA_W-1:0] w_rdat;
  logic [DATA_W-1:0]       w_ldat;

  assign w_accept = (r_state == IDLE) && reqValid;
  assign w_base   = {r_ad[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] r_beat0;

  assign w_bad  = !is_legal(funct3, DATA_W);
  assign w_two  = (32'(r_ad[OFF_W-1:0]) + size_of(r_f3)) > BYTES;
  // Beat 1 data arrives live while beat 0 sits in r_beat0.
  assign w_rdat = (r_state == WAIT1) ? {memRdat, r_beat0} : {{DATA_W{1'b0}}, memRdat};
`else
  int unsigned w_sz;
  logic        w_mis;

  assign w_sz   = size_of(funct3);
  assign w_mis  = ((32'(ad[2:0])) & (w_sz - 32'd1)) != 32'd0;
  assign w_bad  = !is_legal(funct3, DATA_W) || w_mis;
  assign w_two  = 1'b0;
  assign w_rdat = memRdat;
`endif

  lsu_lane_align #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lane (
    .i_off    (r_ad[OFF_W-1:0]),
    .i_funct3 (r_f3),
    .i_wdat   (r_dat),
    .i_rdat   (w_rdat),
    .o_strobe (w_strobe),
    .o_wdat   (w_wdat),
    .o_ldat   (w_ldat)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (reqValid)  w_next = w_bad ? RESP : ISSUE0;
      ISSUE0: if (memReady)  w_next = r_we ? (w_two ? ISSUE1 : RESP) : WAIT0;
      WAIT0:  if (memRvalid) w_next = w_two ? ISSUE1 : RESP;
`ifdef MISALIGN_SPLIT_EN
      ISSUE1: if (memReady)  w_next = r_we ? RESP : WAIT1;
      WAIT1:  if (memRvalid) w_next = RESP;
`endif
      RESP:   if (respReady) w_next = IDLE;
      default:               w_next = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (r_state == IDLE);
    memValid  = 1'b0;
    memWe     = 1'b0;
    memAd     = '0;
    memWdat   = '0;
    memStrobe = '0;
    case (r_state)
      ISSUE0: begin
        memValid  = 1'b1;
        memWe     = r_we;
        memAd     = w_base;
        memWdat   = w_wdat[DATA_W-1:0];
        memStrobe = w_strobe[BYTES-1:0];
      end
`ifdef MISALIGN_SPLIT_EN
      ISSUE1: begin
        memValid  = 1'b1;
        memWe     = r_we;
        memAd     = w_base + ADDR_W'(BYTES);
        memWdat   = w_wdat[2*DATA_W-1:DATA_W];
        memStrobe = w_strobe[2*BYTES-1:BYTES];
      end
`endif
      default: ;
    endcase
    respValid = (r_state == RESP);
    respDat   = (r_state == RESP) ? r_resp_dat : '0;
    respErr   = (r_state == RESP) && r_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ad       <= '0;
      r_dat      <= '0;
      r_f3       <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_resp_dat <= '0;
`ifdef MISALIGN_SPLIT_EN
      r_beat0    <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_ad       <= ad;
        r_dat      <= inDat;
        r_f3       <= funct3;
        r_we       <= reqWrite;
        r_err      <= w_bad;
        r_resp_dat <= '0;
      end
      if (r_state == WAIT0 && memRvalid) begin
`ifdef MISALIGN_SPLIT_EN
        r_beat0 <= memRdat;
`endif
        if (!w_two) r_resp_dat <= w_ldat;
      end
`ifdef MISALIGN_SPLIT_EN
      if (r_state == WAIT1 && memRvalid) r_resp_dat <= w_ldat;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: a 32-bit instance driven by a small bus
// model and a 64-bit instance driven by hand, both checked against fixed vectors.
module tb_lsu_align_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        reqValid, reqReady, reqWrite;
  logic [2:0]  funct3;
  logic [31:0] ad, inDat;
  logic        memValid, memReady, memWe, memRvalid;
  logic [31:0] memAd, memWdat;
  logic [31:0] memRdat = '0;
  logic [3:0]  memStrobe;
  logic        respValid, respReady, respErr;
  logic [31:0] respDat;

  logic        reqValid_64, reqReady_64, reqWrite_64;
  logic [2:0]  funct3_64;
  logic [31:0] ad_64, memAd_64;
  logic [63:0] inDat_64, memWdat_64, memRdat_64, respDat_64;
  logic        memValid_64, memReady_64, memWe_64, memRvalid_64;
  logic [7:0]  memStrobe_64;
  logic        respValid_64, respReady_64, respErr_64;

  lsu_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .funct3(funct3), .ad(ad), .inDat(inDat), .memValid(memValid), .memReady(memReady),
    .memWe(memWe), .memAd(memAd), .memWdat(memWdat), .memStrobe(memStrobe),
    .memRvalid(memRvalid), .memRdat(memRdat), .respValid(respValid), .respReady(respReady),
    .respDat(respDat), .respErr(respErr)
  );

  lsu_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .reqValid(reqValid_64), .reqReady(reqReady_64), .reqWrite(reqWrite_64),
    .funct3(funct3_64), .ad(ad_64), .inDat(inDat_64), .memValid(memValid_64), .memReady(memReady_64),
    .memWe(memWe_64), .memAd(memAd_64), .memWdat(memWdat_64), .memStrobe(memStrobe_64),
    .memRvalid(memRvalid_64), .memRdat(memRdat_64), .respValid(respValid_64), .respReady(respReady_64),
    .respDat(respDat_64), .respErr(respErr_64)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus model for the 32-bit instance: programmable ready and read latency, beat log.
  int          ready_lat = 0, rd_lat = 0, wait_cnt = 0, rd_cnt = 0, lg_n = 0;
  logic [31:0] lg_ad [4];
  logic [31:0] lg_wd [4];
  logic [3:0]  lg_st [4];
  logic        lg_we [4];
  logic        mv_seen = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h2000: return 32'h8001_1234;
      32'h3000: return 32'hA1B2_C3D4;
      32'h3004: return 32'h1122_3344;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    memRvalid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) memRvalid = 1'b1;
    end
    memReady = 1'b0;
    if (memValid) begin
      mv_seen = 1'b1;
      if (wait_cnt >= ready_lat) begin
        memReady = 1'b1;
        wait_cnt = 0;
        if (lg_n < 4) begin
          lg_ad[lg_n] = memAd;
          lg_wd[lg_n] = memWdat;
          lg_st[lg_n] = memStrobe;
          lg_we[lg_n] = memWe;
        end
        lg_n++;
        if (!memWe) begin
          rd_cnt  = rd_lat + 1;
          memRdat = mem_rd(memAd);
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Called at a negedge with the unit idle; hold = cycles to keep respReady low.
  task automatic req32(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int hold,
                       output logic [31:0] rdat, output logic err, output int lat,
                       output logic held);
    lg_n = 0;
    mv_seen = 1'b0;
    reqValid = 1'b1; reqWrite = we; funct3 = f3; ad = a; inDat = d;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!respValid) chk_eq("resp32_timeout", respValid, 1);
    rdat = respDat;
    err  = respErr;
    repeat (hold) @(negedge clk);
    held = respValid && (respErr == err);
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
  endtask

  task automatic req64(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] rd,
                       input int lat, output logic [63:0] d, output logic e,
                       output int mvc, output logic stable, output logic [31:0] first,
                       output logic [7:0] strb);
    int   cyc = 0, wc = 0;
    logic pend = 1'b0, done = 1'b0;
    mvc = 0; stable = 1'b1; first = '0; strb = '0; d = '0; e = 1'b0;
    reqValid_64 = 1'b1; reqWrite_64 = 1'b0; funct3_64 = f3; ad_64 = a; inDat_64 = '0;
    @(posedge clk);
    @(negedge clk);
    reqValid_64 = 1'b0;
    while (!done && cyc < 60) begin
      memRvalid_64 = 1'b0;
      memReady_64  = 1'b0;
      if (respValid_64) begin
        d = respDat_64; e = respErr_64; done = 1'b1;
      end else if (pend) begin
        memRvalid_64 = 1'b1; memRdat_64 = rd; pend = 1'b0;
      end else if (memValid_64) begin
        if (mvc == 0) begin
          first = memAd_64; strb = memStrobe_64;
        end else if (memAd_64 !== first || memStrobe_64 !== strb) begin
          stable = 1'b0;
        end
        mvc++;
        if (wc >= lat) begin
          memReady_64 = 1'b1; pend = 1'b1;
        end else begin
          wc++;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk_eq("resp64_timeout", respValid_64, 1);
    respReady_64 = 1'b1;
    @(negedge clk);
    respReady_64 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d32;
    logic [63:0] d64, fst64;
    logic        e, held, stable, any;
    logic [31:0] fst;
    logic [7:0]  st8;
    int          lat, mvc;

    rst = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; funct3 = '0; ad = '0; inDat = '0; respReady = 1'b0;
    reqValid_64 = 1'b0; reqWrite_64 = 1'b0; funct3_64 = '0; ad_64 = '0; inDat_64 = '0;
    memReady_64 = 1'b0; memRvalid_64 = 1'b0; memRdat_64 = '0; respReady_64 = 1'b0;
    repeat (3) @(negedge clk);

    chk_eq("rst_reqReady",  reqReady,  1);
    chk_eq("rst_memValid",  memValid,  0);
    chk_eq("rst_memWe",     memWe,     0);
    chk_eq("rst_memAd",     memAd,     0);
    chk_eq("rst_memWdat",   memWdat,   0);
    chk_eq("rst_memStrobe", memStrobe, 0);
    chk_eq("rst_respValid", respValid, 0);
    chk_eq("rst_respDat",   respDat,   0);
    chk_eq("rst_respErr",   respErr,   0);
    chk_eq("rst64_reqReady", reqReady_64, 1);
    chk_eq("rst64_memValid", memValid_64, 0);
    rst = 1'b0;
    @(negedge clk);

    // sb 0xAB at 0x1003 -> top lane
    req32(1'b1, F3_B, 32'h1003, 32'h0000_00AB, 0, d32, e, lat, held);
    chk_eq("sb_beats",  32'(lg_n), 1);
    chk_eq("sb_ad",     lg_ad[0], 32'h1000);
    chk_eq("sb_strobe", lg_st[0], 4'b1000);
    chk_eq("sb_wdat",   lg_wd[0], 32'hAB00_0000);
    chk_eq("sb_we",     lg_we[0], 1);
    chk_eq("sb_err",    e, 0);
    chk_eq("sb_dat",    d32, 0);

    // halfword loads from word 0x80011234
    req32(1'b0, F3_H, 32'h2002, '0, 0, d32, e, lat, held);
    chk_eq("lh_dat",    d32, 32'hFFFF_8001);
    chk_eq("lh_lat",    32'(lat), 3);
    chk_eq("lh_strobe", lg_st[0], 4'b1100);
    chk_eq("lh_err",    e, 0);
    req32(1'b0, F3_HU, 32'h2002, '0, 0, d32, e, lat, held);
    chk_eq("lhu_dat",   d32, 32'h0000_8001);
    req32(1'b0, F3_B, 32'h2001, '0, 0, d32, e, lat, held);
    chk_eq("lb1_dat",   d32, 32'h0000_0012);
    req32(1'b0, F3_B, 32'h2003, '0, 0, d32, e, lat, held);
    chk_eq("lb3_dat",   d32, 32'hFFFF_FF80);
    req32(1'b0, F3_BU, 32'h2003, '0, 0, d32, e, lat, held);
    chk_eq("lbu3_dat",  d32, 32'h0000_0080);

`ifdef MISALIGN_SPLIT_EN
    req32(1'b1, F3_W, 32'h3001, 32'h1122_3344, 0, d32, e, lat, held);
    chk_eq("sw_split_beats", 32'(lg_n), 2);
    chk_eq("sw_b0_ad",  lg_ad[0], 32'h3000);
    chk_eq("sw_b0_st",  lg_st[0], 4'b1110);
    chk_eq("sw_b0_wd",  lg_wd[0], 32'h2233_4400);
    chk_eq("sw_b1_ad",  lg_ad[1], 32'h3004);
    chk_eq("sw_b1_st",  lg_st[1], 4'b0001);
    chk_eq("sw_b1_wd",  lg_wd[1], 32'h0000_0011);
    chk_eq("sw_split_err", e, 0);
    req32(1'b0, F3_W, 32'h3002, '0, 0, d32, e, lat, held);
    chk_eq("lw_split_beats", 32'(lg_n), 2);
    chk_eq("lw_split_dat", d32, 32'h3344_A1B2);
    chk_eq("lw_split_err", e, 0);
`else
    req32(1'b0, F3_W, 32'h3001, '0, 4, d32, e, lat, held);
    chk_eq("lw_mis_err",   e, 1);
    chk_eq("lw_mis_nobus", mv_seen, 0);
    chk_eq("lw_mis_held",  held, 1);
    chk_eq("lw_mis_dat",   d32, 0);
    req32(1'b0, F3_H, 32'h2001, '0, 0, d32, e, lat, held);
    chk_eq("lh_mis_err",   e, 1);
`endif

    req32(1'b0, F3_D, 32'h2000, '0, 0, d32, e, lat, held);
    chk_eq("ld32_illegal_err",   e, 1);
    chk_eq("ld32_illegal_nobus", mv_seen, 0);

    // Reset while waiting for read data; the late data must be ignored.
    rd_lat = 3;
    lg_n = 0;
    reqValid = 1'b1; reqWrite = 1'b0; funct3 = F3_W; ad = 32'h2000;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    chk_eq("wait0_reqReady", reqReady, 0);
    chk_eq("wait0_memValid", memValid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("rstw_reqReady",  reqReady, 1);
    chk_eq("rstw_respValid", respValid, 0);
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (respValid || !reqReady) any = 1'b1;
    end
    chk_eq("stray_ignored", any, 0);
    rd_lat = 0;
    req32(1'b0, F3_W, 32'h2000, '0, 0, d32, e, lat, held);
    chk_eq("post_rst_dat", d32, 32'h8001_1234);
    chk_eq("post_rst_err", e, 0);

    // 64-bit instance
    req64(F3_D, 32'h8, 64'h0123_4567_89AB_CDEF, 3, d64, e, mvc, stable, fst, st8);
    chk_eq("ld64_dat",     d64, 64'h0123_4567_89AB_CDEF);
    chk_eq("ld64_err",     e, 0);
    chk_eq("ld64_vcycles", 32'(mvc), 4);
    chk_eq("ld64_stable",  stable, 1);
    chk_eq("ld64_ad",      fst, 32'h8);
    chk_eq("ld64_strobe",  st8, 8'hFF);
    req64(F3_WU, 32'hC, 64'h8765_4321_0000_0000, 0, d64, e, mvc, stable, fst, st8);
    chk_eq("lwu64_dat",    d64, 64'h0000_0000_8765_4321);
    chk_eq("lwu64_ad",     fst, 32'h8);
    chk_eq("lwu64_strobe", st8, 8'hF0);
    req64(F3_W, 32'hC, 64'h8765_4321_0000_0000, 0, d64, e, mvc, stable, fst, st8);
    chk_eq("lw64_dat",     d64, 64'hFFFF_FFFF_8765_4321);
    req64(3'b111, 32'h10, 64'h0, 0, d64, e, mvc, stable, fst, st8);
    fst64 = 64'(mvc);
    chk_eq("f3_111_err",   e, 1);
    chk_eq("f3_111_nobus", fst64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
